// File: rtl/ospi_xfer_engine.sv
// Octal SPI (SDR, 8-bit I/O) single-word transaction sequencer.
// Turns one request-bus load/store into CMD/ADDR/(DUMMY/RDATA | WDATA) pin activity.
module ospi_xfer_engine #(
    parameter logic [7:0] CMD_READ       = 8'h0B,
    parameter logic [7:0] CMD_WRITE      = 8'h02,
    parameter int         DUMMY_CYCLES   = 8,
    parameter int         CS_IDLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        ospi_cs_n,
    output logic        ospi_sck,
    output logic [7:0]  ospi_io_o,
    input  logic [7:0]  ospi_io_i,
    output logic        ospi_oe
);

    localparam int CW = $clog2(CS_IDLE_CYCLES + 1);
    localparam logic [CW-1:0] CLAST = CW'(CS_IDLE_CYCLES - 1);
    localparam logic [3:0] DLAST = 4'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, RESP, CSHI
    } state_t;

    state_t state, state_n;
    logic          phase, phase_n;
    logic [2:0]    slot, slot_n;
    logic [3:0]    dcnt, dcnt_n;
    logic [CW-1:0] ccnt, ccnt_n;
    logic [31:0]   addr_r, wdata_r;
    logic [4:0]    rd_r;
    logic          is_load;
    logic [23:0]   rbuf;
    logic          sel_n, drive_n;
    logic [7:0]    io_n;

    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n = state;
        phase_n = phase;
        slot_n  = slot;
        dcnt_n  = dcnt;
        ccnt_n  = ccnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = CMD;
                    phase_n = 1'b0;
                    slot_n  = 3'd0;
                end
            end
            CMD: begin
                phase_n = ~phase;
                if (phase) begin
                    state_n = ADDR;
                    slot_n  = 3'd0;
                end
            end
            ADDR: begin
                phase_n = ~phase;
                if (phase) begin
                    slot_n = slot + 3'd1;
                    if (slot == 3'd3) begin
                        slot_n = 3'd0;
                        dcnt_n = 4'd0;
                        if (!is_load)
                            state_n = WDATA;
                        else if (DUMMY_CYCLES == 0)
                            state_n = RDATA;
                        else
                            state_n = DUMMY;
                    end
                end
            end
            DUMMY: begin
                phase_n = ~phase;
                if (phase) begin
                    dcnt_n = dcnt + 4'd1;
                    if (dcnt == DLAST) begin
                        state_n = RDATA;
                        slot_n  = 3'd0;
                    end
                end
            end
            RDATA: begin
                phase_n = ~phase;
                if (phase) begin
                    slot_n = slot + 3'd1;
                    if (slot == 3'd3)
                        state_n = RESP;
                end
            end
            WDATA: begin
                phase_n = ~phase;
                if (phase) begin
                    slot_n = slot + 3'd1;
                    if (slot == 3'd3) begin
                        state_n = CSHI;
                        ccnt_n  = '0;
                    end
                end
            end
            // RESP already counts as the first chip-select-high clock
            RESP: begin
                if (CS_IDLE_CYCLES == 1) begin
                    state_n = IDLE;
                end else begin
                    state_n = CSHI;
                    ccnt_n  = CW'(1);
                end
            end
            CSHI: begin
                ccnt_n = ccnt + CW'(1);
                if (ccnt == CLAST)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel_n   = (state_n == CMD) || (state_n == ADDR) || (state_n == DUMMY)
               || (state_n == RDATA) || (state_n == WDATA);
        drive_n = (state_n == CMD) || (state_n == ADDR) || (state_n == WDATA);
        io_n    = ospi_io_o;
        if (sel_n && !phase_n) begin
            unique case (state_n)
                CMD:     io_n = req_is_load ? CMD_READ : CMD_WRITE;
                ADDR:    io_n = addr_r[{~slot_n[1:0], 3'b000} +: 8];
                WDATA:   io_n = wdata_r[{slot_n[1:0], 3'b000} +: 8];
                default: io_n = ospi_io_o;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            slot       <= 3'd0;
            dcnt       <= 4'd0;
            ccnt       <= '0;
            ospi_cs_n  <= 1'b1;
            ospi_sck   <= 1'b0;
            ospi_oe    <= 1'b0;
            ospi_io_o  <= 8'h00;
            resp_valid <= 1'b0;
            resp_rd    <= 5'd0;
            resp_data  <= 32'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            rd_r       <= 5'd0;
            is_load    <= 1'b0;
            rbuf       <= 24'd0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            slot       <= slot_n;
            dcnt       <= dcnt_n;
            ccnt       <= ccnt_n;
            ospi_cs_n  <= !sel_n;
            ospi_sck   <= sel_n && phase_n;
            ospi_oe    <= drive_n;
            ospi_io_o  <= io_n;
            resp_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                rd_r    <= req_rd;
                is_load <= req_is_load;
            end
            // flash drives while sck is high; capture on the edge that ends it
            if (state == RDATA && phase) begin
                rbuf <= {ospi_io_i, rbuf[23:8]};
                if (slot == 3'd3) begin
                    resp_valid <= 1'b1;
                    resp_rd    <= rd_r;
                    resp_data  <= {ospi_io_i, rbuf};
                end
            end
        end
    end

endmodule
